// File: rtl/pipelined_adder.sv
// Pipelined add/subtract of a zero- or sign-extended B to A. The carry chain is cut
// into STAGES chunks with valid/ready flow control and a single global stall.
module pipelined_adder #(
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 8,
    parameter int STAGES  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_A-1:0] a,
    input  logic [WIDTH_B-1:0] b,
    input  logic               sub,
    input  logic               sext_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_A-1:0] s,
    output logic               co,
    output logic               ovf
);

    localparam int CW  = WIDTH_A / STAGES;
    localparam int MSB = WIDTH_A - 1;

    if (STAGES < 1 || (WIDTH_A % STAGES) != 0 || WIDTH_B < 1 || WIDTH_B > WIDTH_A) begin : g_bad_params
        $error("pipelined_adder: illegal WIDTH_A/WIDTH_B/STAGES combination");
    end

    logic               en_s;
    logic [WIDTH_A-1:0] bext_s;

    // Stage k input (from the port for k = 0, else from stage k-1 registers).
    logic               v_in_s   [STAGES];
    logic               c_in_s   [STAGES];
    logic [WIDTH_A-1:0] a_in_s   [STAGES];
    logic [WIDTH_A-1:0] bx_in_s  [STAGES];
    logic [WIDTH_A-1:0] sum_in_s [STAGES];

    logic [CW:0]        part_s   [STAGES];
    logic               c_nx_s   [STAGES];
    logic [WIDTH_A-1:0] sum_nx_s [STAGES];
    logic               ovf_nx_s;

    logic               v_r      [STAGES];
    logic               c_r      [STAGES];
    logic [WIDTH_A-1:0] a_r      [STAGES];
    logic [WIDTH_A-1:0] bx_r     [STAGES];
    logic [WIDTH_A-1:0] sum_r    [STAGES];
    logic               ovf_r;

    assign en_s      = !v_r[STAGES-1] || out_ready;
    assign in_ready  = en_s && !rst;
    assign out_valid = v_r[STAGES-1];
    assign s         = sum_r[STAGES-1];
    assign co        = c_r[STAGES-1];
    assign ovf       = ovf_r;

    // Extend B to the full width according to the per-transaction mode.
    always_comb begin
        if (sext_b) begin
            bext_s = WIDTH_A'($signed(b));
        end else begin
            bext_s = WIDTH_A'(b);
        end
    end

    // Route each stage's operands: subtraction enters as ~Bext with carry-in 1.
    always_comb begin
        v_in_s[0]   = in_valid;
        c_in_s[0]   = sub;
        a_in_s[0]   = a;
        bx_in_s[0]  = sub ? ~bext_s : bext_s;
        sum_in_s[0] = {WIDTH_A{1'b0}};
        for (int k = 1; k < STAGES; k++) begin
            v_in_s[k]   = v_r[k-1];
            c_in_s[k]   = c_r[k-1];
            a_in_s[k]   = a_r[k-1];
            bx_in_s[k]  = bx_r[k-1];
            sum_in_s[k] = sum_r[k-1];
        end
    end

    // Per-stage chunk adder; carry into the MSB is recovered as a ^ b ^ sum there.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            part_s[k]   = {1'b0, a_in_s[k][k*CW +: CW]} + {1'b0, bx_in_s[k][k*CW +: CW]}
                        + {{CW{1'b0}}, c_in_s[k]};
            c_nx_s[k]   = part_s[k][CW];
            sum_nx_s[k] = sum_in_s[k];
            sum_nx_s[k][k*CW +: CW] = part_s[k][CW-1:0];
        end
        ovf_nx_s = a_in_s[STAGES-1][MSB] ^ bx_in_s[STAGES-1][MSB]
                 ^ sum_nx_s[STAGES-1][MSB] ^ c_nx_s[STAGES-1];
    end

    // Pipeline registers; data only moves with a valid token so bubbles never disturb s.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k]   <= 1'b0;
                c_r[k]   <= 1'b0;
                a_r[k]   <= {WIDTH_A{1'b0}};
                bx_r[k]  <= {WIDTH_A{1'b0}};
                sum_r[k] <= {WIDTH_A{1'b0}};
            end
            ovf_r <= 1'b0;
        end else if (en_s) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k] <= v_in_s[k];
                if (v_in_s[k]) begin
                    c_r[k]   <= c_nx_s[k];
                    a_r[k]   <= a_in_s[k];
                    bx_r[k]  <= bx_in_s[k];
                    sum_r[k] <= sum_nx_s[k];
                end
            end
            if (v_in_s[STAGES-1]) begin
                ovf_r <= ovf_nx_s;
            end
        end
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the fixed 8-bit ripple adder.
- Adds, or subtracts, a WIDTH_B-bit operand B to a WIDTH_A-bit operand A.
- B is zero- or sign-extended per transaction.
- The carry chain is split into STAGES registered chunks, so wide datapaths close timing.
- Valid/ready handshakes on both sides; sits between an operand producer and a result consumer in the arithmetic datapath.

Parameters:
- WIDTH_A, 16, width of A and of result S. Must be a multiple of STAGES.
- WIDTH_B, 8, width of B. Must satisfy 1 <= WIDTH_B <= WIDTH_A.
- STAGES, 4, number of pipeline stages, >= 1. Chunk width CW = WIDTH_A/STAGES.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH_A  operand A.
- b  input  WIDTH_B  operand B.
- sub  input  1  1 = A - Bext, 0 = A + Bext.
- sext_b  input  1  1 = sign-extend B, 0 = zero-extend B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH_A  result, modulo 2^WIDTH_A.
- co  output  1  carry out of the MSB. For sub, 1 = no borrow.
- ovf  output  1  signed overflow.

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset state: every stage valid = 0; out_valid = 0, s = 0, co = 0, ovf = 0.
- in_ready is 0 while rst = 1.
- Extension:
  - Bext = b zero-extended to WIDTH_A when sext_b = 0.
  - Bext = b sign-extended (b[WIDTH_B-1] replicated) when sext_b = 1.
  - WIDTH_B = WIDTH_A means no extension.
- Operation:
  - Add: A + Bext, carry-in 0.
  - Sub: A + ~Bext, carry-in 1.
  - co = carry out of bit WIDTH_A-1.
  - ovf = carry into bit WIDTH_A-1 XOR co.
- Pipeline: stage k (0..STAGES-1) computes bits [k*CW +: CW].
  - Stage k uses the carry registered by stage k-1; stage 0 uses carry-in.
  - Upper operand chunks and partial sums are carried forward in skew registers alongside a per-stage valid bit.
  - The final stage registers s, co and ovf.
- Transfers:
  - An input is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
- Stall rule:
  - Global enable en = !out_valid || out_ready; in_ready = en && !rst.
  - When en = 0, all pipeline registers hold.
  - Bubbles are not compressed.
- Latency: with no stall, out_valid rises exactly STAGES cycles after the accepting edge.
  - STAGES = 1 gives one-cycle latency and a single full-width adder.
- Throughput: one result per cycle while out_ready = 1.
- Ordering: results leave in acceptance order, with no loss or duplication.
- Output stability: while out_valid && !out_ready, s, co and ovf hold stable.
- Simultaneous events: accept and consume in the same cycle is legal and keeps full throughput.
- Reset mid-operation: rst clears all stage valids on the next edge. In-flight operands are discarded and never emerge.
- Input masking: with in_valid = 0, a, b, sub and sext_b are don't-care and must not affect any output.
- Elaboration: an illegal parameter combination (WIDTH_A % STAGES != 0, or WIDTH_B > WIDTH_A) is an elaboration error.

Test Plan (WIDTH_A=16, WIDTH_B=8, STAGES=4 unless noted):
1. Basic add, latency: a=0x00FF, b=0x01, sub=0, sext_b=0, out_ready=1 -> s=0x0100, co=0, ovf=0, with out_valid high exactly 4 cycles after acceptance.
2. Carry across all chunks: a=0xFFFF, b=0x01 -> s=0x0000, co=1, ovf=0. Then a=0x7FFF, b=0x01 -> s=0x8000, co=0, ovf=1.
3. Extension mode: a=0x0010, b=0xFF, sext_b=1 -> s=0x000F, co=1. Same operands with sext_b=0 -> s=0x010F, co=0.
4. Subtract: a=0x8000, b=0x01, sub=1, sext_b=0 -> s=0x7FFF, co=1, ovf=1. Then a=0x0000, b=0x01, sub=1 -> s=0xFFFF, co=0, ovf=0.
5. Backpressure: stream 6 back-to-back ops with out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, output holds, all 6 results arrive in order with no duplicates. Repeat with STAGES=1 and STAGES=16.
6. Reset mid-flight: accept 3 ops, assert rst for 1 cycle -> out_valid=0 on the next cycle and stays 0 until new input; none of the 3 results ever appear.
